bp_update_scheduler: RTL and testbench
======================================

// Module: bp_update_scheduler
// PURPOSE
//  Sequences the branch predictor's single update port. Buffers resolved-branch
//  records from MEM in an in-order FIFO and issues them one per accepted cycle.
//  Owns a table-clear sweep FSM that initializes the predictor tables by index
//  after reset or flush, replacing the predictor's per-entry reset loops.
//  Holds IF-stage prediction off (pred_stall) while a sweep runs.
// PARAMETERS
//  DEPTH        4     update FIFO entries; power of 2, >=2
//  ADDR_WIDTH   32    PC/target width
//  CLR_ENTRIES  4096  sweep length = largest predictor table; power of 2
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           async active-low reset
//  flush_req     in   1           1-cycle pulse: discard queue, re-run clear sweep
//  br_valid      in   1           MEM resolved-branch record valid
//  br_ready      out  1           scheduler accepts record this cycle
//  br_pc         in   ADDR_WIDTH  branch PC
//  br_target     in   ADDR_WIDTH  actual target
//  br_flags      in   5           {taken,is_cond,is_call,is_return,mispredict}
//  upd_valid     out  1           update record presented to predictor
//  upd_ready     in   1           predictor accepts update this cycle
//  upd_pc        out  ADDR_WIDTH  head record PC
//  upd_target    out  ADDR_WIDTH  head record target
//  upd_flags     out  5           head record flags, same packing as br_flags
//  clr_valid     out  1           write default value at clr_index in all tables
//  clr_index     out  $clog2(CLR_ENTRIES)  sweep index
//  pred_stall    out  1           predictor outputs invalid; IF uses pc+4
//  q_count       out  $clog2(DEPTH+1)      current FIFO occupancy
// BEHAVIOUR
//  - Clock clk; reset rst_n asynchronous, active-low; all state async-cleared.
//  - States: S_CLEAR, S_RUN. Reset -> S_CLEAR, clr_index=0, q_count=0, pointers=0.
//  - Reset values: br_ready=0, upd_valid=0, clr_valid=1, clr_index=0,
//    pred_stall=1, q_count=0, upd_pc/upd_target/upd_flags=0.
//  - S_CLEAR: clr_valid=1, pred_stall=1, br_ready=0, upd_valid=0; clr_index
//    +1 per cycle; at clr_index==CLR_ENTRIES-1 -> S_RUN next cycle (index -> 0).
//    Sweep takes exactly CLR_ENTRIES cycles.
//  - S_RUN: clr_valid=0, pred_stall=0; br_ready = (q_count<DEPTH), registered-
//    state only (no combinational path from upd_ready).
//  - Push when br_valid&&br_ready: write tail, tail+1 (wraps mod DEPTH).
//  - Pop when upd_valid&&upd_ready: head+1 (wraps); upd_valid=(q_count!=0).
//  - upd_* driven from FIFO head entry; push in cycle N visible as upd_valid in
//    N+1 (latency 1 without bypass). Order strictly preserved.
//  - Simultaneous push+pop: q_count unchanged. Full: br_ready=0. Empty:
//    upd_valid=0, upd_* hold last head contents (don't-care).
//  - flush_req in S_RUN: queue discarded (q_count, pointers -> 0), any same-
//    cycle push and pop ignored, -> S_CLEAR at index 0 next cycle.
//  - flush_req in S_CLEAR: sweep restarts at clr_index=0 next cycle.
//  - upd_ready low while upd_valid: head held stable until accepted.
// CONFIGURATION
//  - BP_UPD_BYPASS_EN defined: in S_RUN with q_count==0 and no flush,
//    an accepted br_* record drives upd_* combinationally in the same cycle;
//    if upd_ready=1 it is consumed and not written (q_count stays 0), else it
//    is written to the FIFO as normal. br_ready still from registered state.
//  - Not defined: no bypass; minimum br->upd latency 1 cycle.
// TESTING
//  - Reset release, CLR_ENTRIES=16 -> clr_valid=1 for 16 cycles, index 0..15,
//    then pred_stall=0, br_ready=1.
//  - Push 4 records (pc 0x100,0x104,0x108,0x10C), upd_ready=0 -> q_count=4,
//    br_ready=0; raise upd_ready -> upd_pc 0x100..0x10C on 4 consecutive cycles.
//  - Push+pop every cycle for 20 cycles -> q_count constant 1, pointers wrap,
//    order intact.
//  - flush_req with q_count=3 and br_valid=1 -> q_count=0 next cycle, no upd_valid
//    until sweep completes; sweep restarts at 0.
//  - flush_req at clr_index=9 -> clr_index=0 next cycle, full sweep repeats.
//  - BP_UPD_BYPASS_EN, empty queue, upd_ready=1, push pc 0x200 -> upd_valid=1,
//    upd_pc=0x200 same cycle, q_count stays 0; without macro -> next cycle.

Source files
------------

// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - branch predictor update FIFO and table-clear sweep sequencer
// Optional feature macro: BP_UPD_BYPASS_EN (same-cycle br->upd bypass when the queue is empty)
module bp_update_scheduler #(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int CLR_ENTRIES = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_req,
  input  logic                           br_valid,
  output logic                           br_ready,
  input  logic [ADDR_WIDTH-1:0]          br_pc,
  input  logic [ADDR_WIDTH-1:0]          br_target,
  input  logic [4:0]                     br_flags,
  output logic                           upd_valid,
  input  logic                           upd_ready,
  output logic [ADDR_WIDTH-1:0]          upd_pc,
  output logic [ADDR_WIDTH-1:0]          upd_target,
  output logic [4:0]                     upd_flags,
  output logic                           clr_valid,
  output logic [$clog2(CLR_ENTRIES)-1:0] clr_index,
  output logic                           pred_stall,
  output logic [$clog2(DEPTH+1)-1:0]     q_count
);

  localparam int IW = $clog2(CLR_ENTRIES);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = 2 * ADDR_WIDTH + 5;
  localparam logic [IW-1:0] CLR_LAST = IW'(CLR_ENTRIES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [RW-1:0]   mem_q [DEPTH];
  logic [RW-1:0]   mem_d [DEPTH];

  logic            run;
  logic            bypass;
  logic            push;
  logic            pop;
  logic [RW-1:0]   br_rec;
  logic [RW-1:0]   upd_rec;

  assign run    = (state_q == S_RUN);
  assign br_rec = {br_pc, br_target, br_flags};

`ifdef BP_UPD_BYPASS_EN
  // An empty queue lets an arriving record go straight to the predictor port.
  assign bypass = run && (count_q == '0) && !flush_req && br_valid;
`else
  assign bypass = 1'b0;
`endif

  // Handshake decode; br_ready depends only on registered state.
  assign br_ready  = run && (count_q < DEPTH_C);
  assign upd_valid = (run && (count_q != '0)) || bypass;
  assign upd_rec   = bypass ? br_rec : mem_q[head_q];
  assign push      = br_valid && br_ready && !flush_req && !(bypass && upd_ready);
  assign pop       = upd_valid && upd_ready && !flush_req && !bypass;

  assign upd_pc     = upd_rec[RW-1 -: ADDR_WIDTH];
  assign upd_target = upd_rec[ADDR_WIDTH+4 -: ADDR_WIDTH];
  assign upd_flags  = upd_rec[4:0];
  assign clr_valid  = !run;
  assign pred_stall = !run;
  assign clr_index  = idx_q;
  assign q_count    = count_q;

  // Next-state: sweep sequencing, flush handling and FIFO pointer/occupancy updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    case (state_q)
      S_CLEAR: begin
        if (flush_req) begin
          idx_d = '0;
        end else if (idx_q == CLR_LAST) begin
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_RUN: begin
        if (flush_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end else begin
          if (push) begin
            mem_d[tail_q] = br_rec;
            tail_d        = tail_q + PW'(1);
          end
          if (pop) begin
            head_d = head_q + PW'(1);
          end
          case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
          endcase
        end
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // State registers, all asynchronously cleared so the sweep starts right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb/tb_bp_update_scheduler.sv - scoreboard bench for bp_update_scheduler
module tb_bp_update_scheduler;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CLR   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_req = 1'b0;
  logic          br_valid = 1'b0;
  logic          br_ready;
  logic [AW-1:0] br_pc = '0;
  logic [AW-1:0] br_target = '0;
  logic [4:0]    br_flags = '0;
  logic          upd_valid;
  logic          upd_ready = 1'b0;
  logic [AW-1:0] upd_pc;
  logic [AW-1:0] upd_target;
  logic [4:0]    upd_flags;
  logic          clr_valid;
  logic [3:0]    clr_index;
  logic          pred_stall;
  logic [2:0]    q_count;

  bp_update_scheduler #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .CLR_ENTRIES(CLR)) dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req),
    .br_valid(br_valid), .br_ready(br_ready), .br_pc(br_pc),
    .br_target(br_target), .br_flags(br_flags),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_flags(upd_flags),
    .clr_valid(clr_valid), .clr_index(clr_index), .pred_stall(pred_stall),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of records awaiting issue plus the sweep position.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
    logic [4:0]    fl;
  } rec_t;

  rec_t exp_q[$];
  bit   mon_en  = 0;
  bit   m_clear = 1;
  int   m_idx   = 0;

  // Monitor: compares every DUT output each cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      rec_t r;
      bit   exp_uv;
      bit   byp;
      bit   accept;
      check("clr_valid", 64'(clr_valid), 64'(m_clear));
      check("pred_stall", 64'(pred_stall), 64'(m_clear));
      if (m_clear) check("clr_index", 64'(clr_index), 64'(m_idx));
      check("q_count", 64'(q_count), 64'(exp_q.size()));
      check("br_ready", 64'(br_ready), 64'(!m_clear && exp_q.size() < DEPTH));
      byp = 0;
`ifdef BP_UPD_BYPASS_EN
      byp = !m_clear && exp_q.size() == 0 && br_valid && !flush_req;
`endif
      exp_uv = (!m_clear && exp_q.size() != 0) || byp;
      check("upd_valid", 64'(upd_valid), 64'(exp_uv));
      accept = br_valid && br_ready && !flush_req;
      if (byp) begin
        check("bypass_pc", 64'(upd_pc), 64'(br_pc));
        check("bypass_target", 64'(upd_target), 64'(br_target));
        check("bypass_flags", 64'(upd_flags), 64'(br_flags));
        if (!upd_ready && accept) exp_q.push_back('{pc: br_pc, tgt: br_target, fl: br_flags});
      end else begin
        if (upd_valid && upd_ready && !flush_req) begin
          if (exp_q.size() == 0) begin
            check("pop_from_empty", 64'(1), 64'(0));
          end else begin
            r = exp_q.pop_front();
            check("upd_pc", 64'(upd_pc), 64'(r.pc));
            check("upd_target", 64'(upd_target), 64'(r.tgt));
            check("upd_flags", 64'(upd_flags), 64'(r.fl));
          end
        end
        if (accept) exp_q.push_back('{pc: br_pc, tgt: br_target, fl: br_flags});
      end
      if (m_clear) begin
        if (flush_req) m_idx = 0;
        else if (m_idx == CLR - 1) begin m_idx = 0; m_clear = 0; end
        else m_idx = m_idx + 1;
      end else if (flush_req) begin
        exp_q.delete();
        m_clear = 1;
        m_idx = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a record on br_* until the DUT takes it, with a bounded wait.
  task automatic send(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic [4:0] fl);
    bit done;
    done = 0;
    br_valid = 1'b1; br_pc = pc; br_target = tgt; br_flags = fl;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (br_ready) done = 1;
      @(posedge clk);
      #1;
    end
    br_valid = 1'b0;
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  // Bounded wait until the sweep is finished.
  task automatic wait_run();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!clr_valid) done = 1;
    end
    @(posedge clk);
    #1;
    if (!done) check("sweep_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    // Reset values while rst_n is held low.
    #12;
    check("rst_br_ready", 64'(br_ready), 64'(0));
    check("rst_upd_valid", 64'(upd_valid), 64'(0));
    check("rst_clr_valid", 64'(clr_valid), 64'(1));
    check("rst_clr_index", 64'(clr_index), 64'(0));
    check("rst_pred_stall", 64'(pred_stall), 64'(1));
    check("rst_q_count", 64'(q_count), 64'(0));
    check("rst_upd_pc", 64'(upd_pc), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1;
    tick(CLR + 2);

    // Fill the queue while the predictor is stalled, then drain in order.
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 5'(i + 1));
    tick(2);
    upd_ready = 1'b1;
    tick(6);

    // Continuous push+pop: occupancy must sit at 1 while pointers wrap.
    br_valid = 1'b1;
    for (int i = 0; i < 21; i++) begin
      br_pc = $urandom; br_target = $urandom; br_flags = 5'($urandom);
      tick(1);
    end
    br_valid = 1'b0;
    tick(3);

    // Flush with three queued records and a record being offered.
    upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 5'($urandom));
    br_valid = 1'b1; br_pc = 32'hDEAD; flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0; br_valid = 1'b0; upd_ready = 1'b1;

    // Flush in the middle of the sweep at clr_index 9.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clr_valid && clr_index == 4'd8) break;
    end
    @(posedge clk);
    #1;
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    wait_run();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      br_valid  = ($urandom_range(0, 3) != 0);
      upd_ready = ($urandom_range(0, 2) != 0);
      br_pc = $urandom; br_target = $urandom; br_flags = 5'($urandom);
      flush_req = ($urandom_range(0, 79) == 0);
      tick(1);
    end
    flush_req = 1'b0; br_valid = 1'b0; upd_ready = 1'b1;
    tick(CLR + 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
